// File: rtl/uart_word_tx.sv
// Word FIFO feeding a UART transmitter: each 24-bit word leaves as three 8N1 frames, low byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits of every frame.
module uart_word_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [23:0] WORD_IN,
  input  logic        WR_EN,
  output logic        FULL,
  output logic        EMPTY,
  output logic        BUSY,
  output logic        WORD_DONE,
  output logic        OVERFLOW,
  output logic        UART_TXD
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic          wr_ok;
  logic          pop;
  logic [23:0]   head;

  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          word_done_q, word_done_d;
  logic          txd_q, txd_d;
  logic          baud_tick;
  logic          last_byte;

  function automatic logic [7:0] byte_of(input logic [23:0] w, input logic [1:0] idx);
    case (idx)
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[7:0];
    endcase
  endfunction

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign baud_tick  = (baud_cnt_q == CW'(DIV - 1));
  assign last_byte  = (byte_idx_q == 2'd2);

  // A write that meets FULL is lost even if the FSM pops in the same cycle.
  always_comb begin
    wr_ok      = WR_EN && !fifo_full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    count_d    = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    overflow_d = overflow_q | (WR_EN & fifo_full);
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) mem_q[wr_ptr_q] <= WORD_IN;
  end

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (baud_tick) state_d = S_DATA;
      S_DATA: begin
        if (baud_tick && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_tick) state_d = S_STOP;
`endif
      S_STOP: begin
        if (baud_tick) state_d = (last_byte && fifo_empty) ? S_IDLE : S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and line output; the line is registered from the next state so it never glitches.
  always_comb begin
    baud_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    tx_byte_d   = tx_byte_q;
    word_done_d = 1'b0;
    pop         = 1'b0;

    if (state_q != S_IDLE && state_q != S_LOAD) begin
      baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        byte_idx_d = 2'd0;
        bit_cnt_d  = 3'd0;
        if (!fifo_empty) begin
          pop    = 1'b1;
          word_d = head;
        end
      end
      S_LOAD: tx_byte_d = byte_of(word_q, byte_idx_q);
      S_DATA: if (baud_tick) bit_cnt_d = bit_cnt_q + 3'd1;
      S_STOP: begin
        if (baud_tick) begin
          if (!last_byte) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_byte_d  = byte_of(word_q, byte_idx_q + 2'd1);
          end else begin
            word_done_d = 1'b1;
            byte_idx_d  = 2'd0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              word_d    = head;
              tx_byte_d = head[7:0];
            end
          end
        end
      end
      default: ;
    endcase

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = tx_byte_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = ^tx_byte_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      tx_byte_q   <= '0;
      word_done_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      tx_byte_q   <= tx_byte_d;
      word_done_q <= word_done_d;
      txd_q       <= txd_d;
    end
  end

  assign FULL      = fifo_full;
  assign EMPTY     = fifo_empty;
  assign BUSY      = (state_q != S_IDLE);
  assign WORD_DONE = word_done_q;
  assign OVERFLOW  = overflow_q;
  assign UART_TXD  = txd_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx at DIV=16: a line monitor decodes frames into words and checks them
// against a queue of words pushed as they are written.
module tb_uart_word_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CLKS = 3 * FRAME * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] word_in = '0;
  logic        wr_en = 1'b0;
  logic        full, empty, busy, word_done, overflow, txd;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] sb[$];
  int          word_starts[$];
  int          rst_gen = 0;
  int          exp_done = -1;
  int          done_cnt = 0;

  logic [23:0] burst [6] = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'h5A5A5A, 24'h8001C3, 24'h777777};
  logic [23:0] chain [6] = '{24'h010203, 24'h0A0B0C, 24'hF0E1D2, 24'h3C3C3C, 24'h9E8D7C, 24'h246813};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_tx #(.CLK_HZ(16), .BAUD(1), .DEPTH(4)) dut (
    .CLOCK_50 (clk),
    .RST      (rst_n),
    .WORD_IN  (word_in),
    .WR_EN    (wr_en),
    .FULL     (full),
    .EMPTY    (empty),
    .BUSY     (busy),
    .WORD_DONE(word_done),
    .OVERFLOW (overflow),
    .UART_TXD (txd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; the word is captured on the next posedge.
  task automatic wr(input logic [23:0] w, input bit accept);
    word_in = w;
    wr_en   = 1'b1;
    if (accept) sb.push_back(w);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input int n_done, input int budget);
    int t = 0;
    while ((sb.size() != 0 || done_cnt < n_done) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
    check("done_count", done_cnt, n_done);
    @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("empty_after", empty, 1'b1);
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < word_starts.size(); i++)
      check(tag, word_starts[i] - word_starts[i-1], WORD_CLKS);
  endtask

  // Line monitor: mid-bit sampling, three frames per word.
  initial begin : monitor
    int          nb;
    int          g;
    int          fs;
    int          ws;
    logic [23:0] acc;
    logic [7:0]  d;
    logic        st, sp;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif
    nb = 0;
    g  = 0;
    ws = 0;
    acc = '0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        if (g != rst_gen) begin
          nb = 0;
          g  = rst_gen;
        end
        fs = cyc;
        repeat (DIV/2) @(negedge clk);
        st = txd;
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          d[b] = txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        par = txd;
`endif
        repeat (DIV) @(negedge clk);
        sp = txd;
        if (g != rst_gen) begin
          nb = 0;
          g  = rst_gen;
          continue;
        end
        check("start_bit", st, 1'b0);
        check("stop_bit", sp, 1'b1);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", par, ^d);
`endif
        if (nb == 0) ws = fs;
        else check("byte_spacing", fs - ws, nb * FRAME * DIV);
        acc[8*nb +: 8] = d;
        nb++;
        if (nb == 3) begin
          nb = 0;
          word_starts.push_back(ws);
          exp_done = ws + WORD_CLKS;
          check("rx_word_expected", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) check("rx_word", acc, sb.pop_front());
          $display("rx word 0x%06h start cycle %0d", acc, ws);
        end
      end
    end
  end

  initial begin : done_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (word_done === 1'b1) begin
        check("word_done_time", cyc, exp_done);
        check("word_done_width", prev, 1'b0);
        done_cnt++;
      end
      prev = word_done;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p;
    int viol;

    // Reset and idle line
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_word_done", word_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("idle_1000", viol, 0);

    // Single word, latency and framing
    sync();
    p = cyc;
    word_starts.delete();
    done_cnt = 0;
    wr(24'hA5C301, 1'b1);
    check("single_empty_n1", empty, 1'b0);
    check("single_busy_n1", busy, 1'b0);
    sync();
    check("single_busy_load", busy, 1'b1);
    check("single_txd_load", txd, 1'b1);
    sync();
    check("single_txd_start", txd, 1'b0);
    drain(1, WORD_CLKS + 100);
    check("single_words", word_starts.size(), 1);
    if (word_starts.size() > 0) check("single_latency", word_starts[0], p + 3);
    $display("single word 0x%06h sent", 24'hA5C301);

    // Burst of six writes on consecutive clocks
    sync();
    word_starts.delete();
    done_cnt = 0;
    for (int i = 0; i < 4; i++) wr(burst[i], 1'b1);
    check("burst_full_4", full, 1'b0);
    wr(burst[4], 1'b1);
    check("burst_full_5", full, 1'b1);
    check("burst_ovf_5", overflow, 1'b0);
    wr(burst[5], 1'b0);
    check("burst_ovf_6", overflow, 1'b1);
    check("burst_full_6", full, 1'b1);
    drain(5, 5 * WORD_CLKS + 200);
    check("burst_words", word_starts.size(), 5);
    check_gaps("burst_gap");
    check("burst_ovf_sticky", overflow, 1'b1);
    $display("burst of 6 writes, 5 words sent");

    // Reset in the middle of byte 1 with two words queued
    sync();
    word_starts.delete();
    done_cnt = 0;
    wr(24'hFF00AA, 1'b1);
    wr(24'h111111, 1'b1);
    wr(24'h222222, 1'b1);
    repeat (FRAME * DIV + FRAME * DIV / 2) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_pre", busy, 1'b1);
    check("midrst_empty_pre", empty, 1'b0);
    check("midrst_txd_pre", txd, 1'b0);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    sb.delete();
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_empty", empty, 1'b1);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_full", full, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("midrst_idle", viol, 0);
    check("midrst_words", word_starts.size(), 0);
    check("midrst_done", done_cnt, 0);
    $display("reset mid-frame, line idle afterwards");

    // Write coinciding with the end-of-word pop while two words are queued
    sync();
    word_starts.delete();
    done_cnt = 0;
    wr(chain[0], 1'b1);
    wr(chain[1], 1'b1);
    wr(chain[2], 1'b1);
    repeat (WORD_CLKS - 1) @(posedge clk);
    #1;
    check("pop_full_pre", full, 1'b0);
    check("pop_empty_pre", empty, 1'b0);
    wr(chain[3], 1'b1);
    check("pop_full_same", full, 1'b0);
    check("pop_empty_same", empty, 1'b0);
    check("pop_busy_same", busy, 1'b1);
    wr(chain[4], 1'b1);
    check("pop_full_3", full, 1'b0);
    wr(chain[5], 1'b1);
    check("pop_full_4", full, 1'b1);
    check("pop_ovf", overflow, 1'b0);
    drain(6, 6 * WORD_CLKS + 200);
    check("pop_words", word_starts.size(), 6);
    check_gaps("pop_gap");
    $display("write during pop, 6 words sent in order");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
